shift_unit_pipelined: RTL

- Parametrised, pipelined successor to the single-cycle combinational shifter in the execute stage.
- Supports SLL, SRL, SRA, ROL and ROR on an XLEN-wide operand.
- The log2(XLEN) barrel levels are spread over STAGES register slices, with valid/ready handshake, full-pipeline stall and flush.
- Intended for higher-frequency RS5 configurations and for Zbb rotate support.

---
 rtl/shift_unit_pipelined.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/shift_unit_pipelined.sv
// rtl/shift_unit_pipelined.sv - pipelined SLL/SRL/SRA/ROL/ROR barrel shifter with valid/ready, stall and flush
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   flush_i      synchronous kill of every in-flight operation
//   in_valid_i   operation presented        in_ready_o  operation accepted this cycle
//   operand_i    value to shift             shamt_i     shift amount (log2(XLEN) bits)
//   op_i         0=SLL 1=SRL 2=SRA 3=ROL 4=ROR 5..7=SLL
//   tag_i        destination tag, carried unchanged to tag_o
//   out_valid_o  result valid               out_ready_i consumer takes result
//   result_o     shifted result (0 when out_valid_o=0)
//   tag_o        tag of result_o (0 when out_valid_o=0)

module shift_unit_pipelined #(
  parameter int XLEN      = 32,
  parameter int STAGES    = 2,
  parameter bit ROTATE_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [XLEN-1:0]          operand_i,
  input  logic [$clog2(XLEN)-1:0]  shamt_i,
  input  logic [2:0]               op_i,
  input  logic [4:0]               tag_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic [4:0]               tag_o
);

  localparam int L  = $clog2(XLEN);
  // Control (shamt/op/sign) only has to reach the stages that still have
  // levels to apply, so the output slice does not carry it.
  localparam int CS = (STAGES > 1) ? STAGES - 1 : 1;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  // Barrel level j (shift by 2^j) is evaluated in stage floor(j*STAGES/L).
  function automatic int stage_of(input int j);
    return (j * STAGES) / L;
  endfunction

  // One barrel level: shift/rotate x by k (1 <= k <= XLEN/2).
  function automatic logic [XLEN-1:0] shift_level(
    input logic [XLEN-1:0] x,
    input logic [2:0]      op,
    input logic            sgn,
    input int              k
  );
    logic [XLEN-1:0] r;
    case (op)
      OP_SRL:  r = x >> k;
      OP_SRA:  r = (x >> k) | (sgn ? ~({XLEN{1'b1}} >> k) : '0);
      OP_ROL:  r = (x << k) | (x >> (XLEN - k));
      OP_ROR:  r = (x >> k) | (x << (XLEN - k));
      default: r = x << k;
    endcase
    return r;
  endfunction

  // Opcode normalisation happens once at the input so later stages only
  // ever see the five real operations.
  logic [2:0] op_dec;

  always_comb begin
    op_dec = OP_SLL;
    case (op_i)
      3'd1:    op_dec = OP_SRL;
      3'd2:    op_dec = OP_SRA;
      3'd3:    op_dec = ROTATE_EN ? OP_ROL : OP_SLL;
      3'd4:    op_dec = ROTATE_EN ? OP_ROR : OP_SRL;
      default: op_dec = OP_SLL;
    endcase
  end

  // Register slices
  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0][XLEN-1:0]  data_q,  data_d;
  logic [STAGES-1:0][4:0]       tag_q,   tag_d;
  logic [CS-1:0][L-1:0]         shamt_q, shamt_d;
  logic [CS-1:0][2:0]           op_q,    op_d;
  logic [CS-1:0]                sign_q,  sign_d;

  // Inputs seen by each stage: stage 0 takes the port, stage s takes slice s-1.
  logic [STAGES-1:0]            st_valid;
  logic [STAGES-1:0][XLEN-1:0]  st_data;
  logic [STAGES-1:0][4:0]       st_tag;
  logic [STAGES-1:0][L-1:0]     st_shamt;
  logic [STAGES-1:0][2:0]       st_op;
  logic [STAGES-1:0]            st_sign;
  logic [STAGES-1:0][XLEN-1:0]  stage_out;

  logic advance;

  always_comb begin : stage_inputs
    st_valid    = '0;
    st_data     = '0;
    st_tag      = '0;
    st_shamt    = '0;
    st_op       = '0;
    st_sign     = '0;
    st_valid[0] = in_valid_i;
    st_data[0]  = operand_i;
    st_tag[0]   = tag_i;
    st_shamt[0] = shamt_i;
    st_op[0]    = op_dec;
    st_sign[0]  = operand_i[XLEN-1];
    for (int s = 1; s < STAGES; s++) begin
      st_valid[s] = valid_q[s-1];
      st_data[s]  = data_q[s-1];
      st_tag[s]   = tag_q[s-1];
      st_shamt[s] = shamt_q[s-1];
      st_op[s]    = op_q[s-1];
      st_sign[s]  = sign_q[s-1];
    end
  end

  // Each stage applies only its own levels, using the op/sign/shamt that
  // travelled with its entry rather than whatever is on the input port.
  always_comb begin : barrel
    logic [XLEN-1:0] x;
    x         = '0;
    stage_out = '0;
    for (int s = 0; s < STAGES; s++) begin
      x = st_data[s];
      for (int j = 0; j < L; j++) begin
        if (stage_of(j) == s && st_shamt[s][j]) begin
          x = shift_level(x, st_op[s], st_sign[s], 1 << j);
        end
      end
      stage_out[s] = x;
    end
  end

  // Single global enable: the whole pipe moves or the whole pipe holds,
  // bubbles included.
  assign out_valid_o = valid_q[STAGES-1];
  assign advance     = !out_valid_o || out_ready_i;
  assign in_ready_o  = advance;

  always_comb begin : next_state
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    sign_d  = sign_q;
    if (advance) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_d[s] = st_valid[s];
        data_d[s]  = stage_out[s];
        tag_d[s]   = st_tag[s];
      end
      for (int s = 0; s < STAGES - 1; s++) begin
        shamt_d[s] = st_shamt[s];
        op_d[s]    = st_op[s];
        sign_d[s]  = st_sign[s];
      end
    end
    // Flush overrides advance; data left behind is don't-care because the
    // output is gated by valid.
    if (flush_i) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      shamt_q <= '0;
      op_q    <= '0;
      sign_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
    end
  end

  // Keep stale slice contents from leaking out while nothing is valid.
  assign result_o = out_valid_o ? data_q[STAGES-1] : '0;
  assign tag_o    = out_valid_o ? tag_q[STAGES-1]  : '0;

endmodule
